// File: rtl/irrigation_pkg.sv
// Shared state encoding and helpers for the multi-zone irrigation scheduler.
package irrigation_pkg;

    localparam int STATE_W   = 3;
    localparam int MAX_ZONES = 8;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE     = 3'd0,
        ST_SCAN     = 3'd1,
        ST_IRRIGATE = 3'd2,
        ST_REFILL   = 3'd3,
        ST_FAULT    = 3'd4
    } state_e;

    // Probe readings that cannot happen with a physically consistent tank.
    function automatic logic conflict_f(
        input logic low,
        input logic mid,
        input logic high
    );
        return (mid & ~low) | (high & ~mid);
    endfunction

    function automatic logic [MAX_ZONES-1:0] zone_onehot(
        input logic [2:0] idx
    );
        logic [MAX_ZONES-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/multi_zone_irrigation_scheduler_debouncer.sv
// Two-flop synchroniser followed by a per-bit tick-based stability filter.
module sensor_debouncer #(
    parameter int W      = 1,
    parameter int SETTLE = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         tick_i,
    input  logic [W-1:0] raw_i,
    output logic [W-1:0] deb_o
);

    localparam int CW = $clog2(SETTLE + 1);

    logic [W-1:0] sync1_q, sync2_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
        end
    end

    for (genvar i = 0; i < W; i++) begin : g_bit
        logic [CW-1:0] cnt_q;
        logic          deb_q;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                cnt_q <= '0;
                deb_q <= 1'b0;
            end else if (tick_i) begin
                if (sync2_q[i] == deb_q) begin
                    cnt_q <= '0;
                end else if (cnt_q == CW'(SETTLE - 1)) begin
                    deb_q <= sync2_q[i];
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end

        assign deb_o[i] = deb_q;
    end

endmodule

// File: rtl/multi_zone_irrigation_scheduler.sv
// Round-robin multi-zone irrigation scheduler sharing one pump/dripper pair.
// All decisions run on debounced sensors and advance only on the tick.
module multi_zone_irrigation_scheduler
    import irrigation_pkg::*;
#(
    parameter int  ZONES        = 4,
    parameter int  TICK_DIV     = 1000,
    parameter int  DWELL_TICKS  = 16,
    parameter int  SETTLE_TICKS = 4,
    localparam int PW = (ZONES > 1) ? $clog2(ZONES) : 1
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               low_water_level,
    input  logic               mid_water_level,
    input  logic               high_water_level,
    input  logic [ZONES-1:0]   earth_humidity,
    input  logic               air_humidity,
    input  logic               low_temperature,
    output logic               water_supply_valvule,
    output logic               splinker_bomb,
    output logic               dripper_valvule,
    output logic [ZONES-1:0]   zone_valves,
    output logic [PW-1:0]      active_zone,
    output logic               alarm,
    output logic [STATE_W-1:0] fsm_state,
    output logic               tick
);

    localparam int TW = $clog2(TICK_DIV);
    localparam int DW = $clog2(DWELL_TICKS + 1);
    localparam int FW = $clog2(SETTLE_TICKS + 1);
    localparam int NS = ZONES + 5;

    logic [TW-1:0] tcnt_q;
    logic          tick_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tcnt_q <= '0;
            tick_q <= 1'b0;
        end else begin
            tick_q <= (tcnt_q == TW'(TICK_DIV - 1));
            tcnt_q <= (tcnt_q == TW'(TICK_DIV - 1)) ? '0 : tcnt_q + 1'b1;
        end
    end

    logic [NS-1:0]    deb;
    logic             lo, mi, hi, air, cold, confl;
    logic [ZONES-1:0] hum;

    sensor_debouncer #(
        .W      (NS),
        .SETTLE (SETTLE_TICKS)
    ) u_deb (
        .clk_i  (clock),
        .rst_ni (reset_n),
        .tick_i (tick_q),
        .raw_i  ({earth_humidity, low_temperature, air_humidity,
                  high_water_level, mid_water_level, low_water_level}),
        .deb_o  (deb)
    );

    assign lo    = deb[0];
    assign mi    = deb[1];
    assign hi    = deb[2];
    assign air   = deb[3];
    assign cold  = deb[4];
    assign hum   = deb[NS-1:5];
    assign confl = conflict_f(lo, mi, hi);

    state_e        state_q, state_d;
    logic [PW-1:0] ptr_q, ptr_d, ptr_nxt, lap_q, lap_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          mode_q, mode_d, blink_q, blink_d;

    assign ptr_nxt = (ptr_q == PW'(ZONES - 1)) ? '0 : ptr_q + 1'b1;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            lap_q   <= '0;
            dwell_q <= '0;
            fcnt_q  <= '0;
            mode_q  <= 1'b0;
            blink_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            lap_q   <= lap_d;
            dwell_q <= dwell_d;
            fcnt_q  <= fcnt_d;
            mode_q  <= mode_d;
            blink_q <= blink_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        lap_d   = lap_q;
        dwell_d = dwell_q;
        fcnt_d  = fcnt_q;
        mode_d  = mode_q;
        blink_d = blink_q;
        if (tick_q) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (confl) begin
                        state_d = ST_FAULT;
                    end else if (!lo) begin
                        state_d = ST_REFILL;
                    end else if (|(~hum)) begin
                        state_d = ST_SCAN;
                        lap_d   = '0;
                    end
                end
                ST_SCAN: begin
                    if (confl) begin
                        state_d = ST_FAULT;
                    end else if (!lo) begin
                        state_d = ST_REFILL;
                    end else if (!hum[ptr_q]) begin
                        state_d = ST_IRRIGATE;
                        dwell_d = DW'(DWELL_TICKS);
                        mode_d  = mi & ~air & ~cold;
                    end else begin
                        ptr_d = ptr_nxt;
                        if (lap_q == PW'(ZONES - 1)) begin
                            state_d = ST_IDLE;
                        end else begin
                            lap_d = lap_q + 1'b1;
                        end
                    end
                end
                ST_IRRIGATE: begin
                    if (confl) begin
                        state_d = ST_FAULT;
                    end else if (!lo) begin
                        state_d = ST_REFILL;
                    end else if (dwell_q <= DW'(1) || hum[ptr_q]) begin
                        state_d = ST_SCAN;
                        ptr_d   = ptr_nxt;
                        lap_d   = '0;
                        dwell_d = '0;
                    end else begin
                        dwell_d = dwell_q - 1'b1;
                    end
                end
                ST_REFILL: begin
                    if (confl) begin
                        state_d = ST_FAULT;
                    end else if (lo) begin
                        state_d = ST_SCAN;
                        lap_d   = '0;
                    end
                end
                ST_FAULT: begin
                    if (confl) begin
                        fcnt_d = '0;
                    end else if (fcnt_q == FW'(SETTLE_TICKS - 1)) begin
                        state_d = ST_IDLE;
                        fcnt_d  = '0;
                    end else begin
                        fcnt_d = fcnt_q + 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
            // Blink starts lit on entry and flips on every tick spent in fault.
            if (state_d == ST_FAULT && state_q != ST_FAULT) begin
                blink_d = 1'b1;
                fcnt_d  = '0;
            end else if (state_q == ST_FAULT) begin
                blink_d = ~blink_q;
            end
        end
    end

    logic [ZONES-1:0] zv_d, zv_q;
    logic             spr_d, spr_q, drip_d, drip_q;
    logic             wsv_d, wsv_q, alarm_d, alarm_q;

    always_comb begin
        zv_d    = '0;
        spr_d   = 1'b0;
        drip_d  = 1'b0;
        wsv_d   = ~hi & ~confl;
        alarm_d = ~mi;
        if (state_q == ST_IRRIGATE) begin
            zv_d   = ZONES'(zone_onehot(3'(ptr_q)));
            spr_d  = mode_q;
            drip_d = ~mode_q;
        end
        if (state_q == ST_FAULT) begin
            wsv_d   = 1'b0;
            alarm_d = blink_q;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            zv_q    <= '0;
            spr_q   <= 1'b0;
            drip_q  <= 1'b0;
            wsv_q   <= 1'b0;
            alarm_q <= 1'b0;
        end else begin
            zv_q    <= zv_d;
            spr_q   <= spr_d;
            drip_q  <= drip_d;
            wsv_q   <= wsv_d;
            alarm_q <= alarm_d;
        end
    end

    assign zone_valves          = zv_q;
    assign splinker_bomb        = spr_q;
    assign dripper_valvule      = drip_q;
    assign water_supply_valvule = wsv_q;
    assign alarm                = alarm_q;
    assign active_zone          = ptr_q;
    assign fsm_state            = state_q;
    assign tick                 = tick_q;

endmodule
